// File: rtl/fpu_pkg.sv
// Shared types and format helpers for the parameterised add/sub FPU.
// Format words are built at a fixed maximum width; callers slice to their own width.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fpu_state_e;

    localparam int FLAG_W        = 4;
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // guard, round, sticky
    localparam int GRS_W = 3;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] fpu_word_t;

    function automatic int fpu_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic fpu_word_t fpu_inf(input int exp_w, input int man_w, input logic sign);
        fpu_word_t w;
        w = ((fpu_word_t'(1) << exp_w) - fpu_word_t'(1)) << man_w;
        w = w | (fpu_word_t'(sign) << (exp_w + man_w));
        return w;
    endfunction

    function automatic fpu_word_t fpu_nan(input int exp_w, input int man_w);
        return fpu_inf(exp_w, man_w, 1'b0) | (fpu_word_t'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/param_fpu_addsub_if.sv
// Operand/result handshake bundle for param_fpu_addsub.
interface param_fpu_addsub_if
    import fpu_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              op;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      result;
    logic [FLAG_W-1:0] flags;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, result, flags, out_valid
    );

    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, result, flags, out_valid
    );

endinterface

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even on a normalised significand with guard/round/sticky.
// A carry out of the significand bumps the exponent and leaves a zero fraction.
module fpu_round_rne #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic [MAN_W:0]   sig_i,
    input  logic             guard_i,
    input  logic             round_i,
    input  logic             sticky_i,
    input  logic [EXP_W:0]   exp_i,
    output logic [MAN_W-1:0] frac_o,
    output logic [EXP_W:0]   exp_o,
    output logic             inexact_o
);
    localparam int XW = EXP_W + 1;
    localparam int RW = MAN_W + 2;

    logic          up;
    logic [RW-1:0] sum;

    always_comb begin
        up        = guard_i & (round_i | sticky_i | sig_i[0]);
        sum       = {1'b0, sig_i} + RW'(up);
        inexact_o = guard_i | round_i | sticky_i;
        if (sum[RW-1]) begin
            frac_o = sum[MAN_W:1];
            exp_o  = exp_i + XW'(1);
        end else begin
            frac_o = sum[MAN_W-1:0];
            exp_o  = exp_i;
        end
    end

endmodule

// File: rtl/param_fpu_addsub.sv
// Multi-cycle floating-point adder/subtractor, one operation in flight.
// Datapath: ALIGN -> ADD -> NORM (one shift per cycle) -> ROUND -> DONE.
module param_fpu_addsub
    import fpu_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    param_fpu_addsub_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SW    = MAN_W + 1 + GRS_W;
    localparam int XW    = EXP_W + 1;
    localparam int CLAMP = MAN_W + GRS_W;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = W'(fpu_nan(EXP_W, MAN_W));
    localparam logic [GRS_W-1:0] GRS0     = '0;
    localparam logic [SW-1:0]    ONES_SW  = '1;

    fpu_state_e state_q, state_d;

    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic              op_q, op_d;
    logic [SW:0]       man_q, man_d;
    logic [SW-1:0]     sml_q, sml_d;
    logic [XW-1:0]     exp_q, exp_d;
    logic              sign_q, sign_d, sub_q, sub_d, uf_q, uf_d;
    logic [W-1:0]      result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    // operand decode; b carries its effective sign
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    assign {sa, ea, fa} = a_q;
    assign sb = b_q[W-1] ^ op_q;
    assign eb = b_q[W-2:MAN_W];
    assign fb = b_q[MAN_W-1:0];

    logic za, zb, ia, ib, na, nb;
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == EXP_ONES) && (fa == '0);
    assign ib = (eb == EXP_ONES) && (fb == '0);
    assign na = (ea == EXP_ONES) && (fa != '0);
    assign nb = (eb == EXP_ONES) && (fb != '0);

    logic              special;
    logic [W-1:0]      spec_res;
    logic [FLAG_W-1:0] spec_flg;

    always_comb begin
        special  = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (na || nb || (ia && ib && (sa != sb))) begin
            spec_res              = QNAN;
            spec_flg[FLG_INVALID] = 1'b1;
        end else if (ia) begin
            spec_res = a_q;
        end else if (ib) begin
            spec_res = {sb, eb, fb};
        end else if (za && zb) begin
            spec_res = '0;
        end else if (za) begin
            spec_res = {sb, eb, fb};
        end else if (zb) begin
            spec_res = a_q;
        end else begin
            special = 1'b0;
        end
    end

    // alignment: larger magnitude first, smaller shifted right with sticky
    logic             a_big, s_big;
    logic [EXP_W-1:0] e_big, e_sml, ediff;
    logic [MAN_W-1:0] f_big, f_sml;
    logic [SW-1:0]    sig_sml, sml_shift;
    logic             lost;

    assign a_big = (a_q[W-2:0] >= b_q[W-2:0]);
    assign e_big = a_big ? ea : eb;
    assign e_sml = a_big ? eb : ea;
    assign f_big = a_big ? fa : fb;
    assign f_sml = a_big ? fb : fa;
    assign s_big = a_big ? sa : sb;
    assign ediff = e_big - e_sml;

    always_comb begin
        sig_sml      = {1'b1, f_sml, GRS0};
        lost         = |(sig_sml & ~(ONES_SW << ediff));
        sml_shift    = sig_sml >> ediff;
        sml_shift[0] = sml_shift[0] | lost;
        // beyond the sticky position only the nonzero-ness survives
        if (int'(ediff) >= CLAMP) sml_shift = SW'(1);
    end

    logic [SW:0] sum;
    logic        sum_zero;
    assign sum      = sub_q ? (man_q - {1'b0, sml_q}) : (man_q + {1'b0, sml_q});
    assign sum_zero = (sum == '0);

    logic carry, lead, norm_shl;
    assign carry    = man_q[SW];
    assign lead     = man_q[SW-1];
    assign norm_shl = !carry && !lead && (exp_q > XW'(1));

    logic [MAN_W-1:0] rnd_frac;
    logic [XW-1:0]    rnd_exp;
    logic             rnd_inx;

    fpu_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sig_i     (man_q[SW-1:GRS_W]),
        .guard_i   (man_q[2]),
        .round_i   (man_q[1]),
        .sticky_i  (man_q[0]),
        .exp_i     (exp_q),
        .frac_o    (rnd_frac),
        .exp_o     (rnd_exp),
        .inexact_o (rnd_inx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = (special || sum_zero) ? DONE : NORM;
            NORM:    if (!norm_shl) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.flags     = flags_q;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        man_d    = man_q;
        sml_d    = sml_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        uf_d     = uf_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d  = bus.a;
                    b_d  = bus.b;
                    op_d = bus.op;
                end
            end
            ALIGN: begin
                man_d  = {1'b0, 1'b1, f_big, GRS0};
                sml_d  = sml_shift;
                exp_d  = {1'b0, e_big};
                sign_d = s_big;
                sub_d  = sa ^ sb;
                uf_d   = 1'b0;
            end
            ADD: begin
                man_d = sum;
                if (special) begin
                    result_d = spec_res;
                    flags_d  = spec_flg;
                end else if (sum_zero) begin
                    result_d = '0;
                    flags_d  = '0;
                end
            end
            NORM: begin
                if (carry) begin
                    man_d = {1'b0, man_q[SW:2], man_q[1] | man_q[0]};
                    exp_d = exp_q + XW'(1);
                end else if (norm_shl) begin
                    man_d = man_q << 1;
                    exp_d = exp_q - XW'(1);
                end else if (!lead) begin
                    uf_d = 1'b1;
                end
            end
            ROUND: begin
                flags_d = '0;
                if (uf_q) begin
                    result_d               = '0;
                    flags_d[FLG_UNDERFLOW] = 1'b1;
                end else if (rnd_exp >= {1'b0, EXP_ONES}) begin
                    result_d              = W'(fpu_inf(EXP_W, MAN_W, sign_q));
                    flags_d[FLG_OVERFLOW] = 1'b1;
                    flags_d[FLG_INEXACT]  = 1'b1;
                end else begin
                    result_d             = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                    flags_d[FLG_INEXACT] = rnd_inx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            man_q    <= '0;
            sml_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            uf_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            man_q    <= man_d;
            sml_q    <= sml_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            uf_q     <= uf_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_param_fpu_addsub.sv
// Directed scoreboard bench for param_fpu_addsub at the default 4/3 format.
module tb_param_fpu_addsub;
    import fpu_pkg::*;

    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] ONE = W'(fpu_bias(EXP_W) << MAN_W);
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INX  = 4'b0001;
    localparam logic [3:0] F_UF   = 4'b0010;
    localparam logic [3:0] F_OVX  = 4'b0101;
    localparam logic [3:0] F_INV  = 4'b1000;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic [7:0]   lat;
    } exp_t;

    logic clk, rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    param_fpu_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    param_fpu_addsub #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic iop, input logic [W-1:0] er, input logic [3:0] ef,
                          input int elat, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        e.res = er;
        e.flg = ef;
        e.lat = 8'(elat);
        sb_q.push_back(e);
        @(negedge clk);
        check({tag, "/in_ready"}, 32'(bus.in_ready), 32'(1));
        bus.a         = ia;
        bus.b         = ib;
        bus.op        = iop;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~ia;
        bus.b        = ~ib;
        bus.op       = ~iop;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = sb_q.pop_front();
        check({tag, "/latency"}, 32'(lat), 32'(got.lat));
        check({tag, "/result"}, 32'(bus.result), 32'(got.res));
        check({tag, "/flags"}, 32'(bus.flags), 32'(got.flg));
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                check({tag, "/held"}, {23'd0, bus.out_valid, bus.result}, {23'd0, 1'b1, got.res});
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "/handshake"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen_valid;
        rst           = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #11;
        check("reset/out_valid", 32'(bus.out_valid), 32'(0));
        check("reset/in_ready", 32'(bus.in_ready), 32'(0));
        check("reset/result", 32'(bus.result), 32'(0));
        check("reset/flags", 32'(bus.flags), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset/in_ready_rise", 32'(bus.in_ready), 32'(1));

        run_op("one_plus_one",  ONE,   ONE,   1'b0, 8'h40, F_NONE, 4, 0);
        run_op("stall_1p5_025", 8'h3C, 8'h28, 1'b0, 8'h3E, F_NONE, 4, 5);
        run_op("cancel_3shift", 8'h39, ONE,   1'b1, 8'h20, F_NONE, 7, 0);
        run_op("cancel_zero",   ONE,   ONE,   1'b1, 8'h00, F_NONE, 2, 0);
        run_op("tie_even_down", ONE,   8'h18, 1'b0, 8'h38, F_INX,  4, 0);
        run_op("tie_even_up",   8'h39, 8'h18, 1'b0, 8'h3A, F_INX,  4, 0);
        run_op("round_carry",   8'h3F, 8'h18, 1'b0, 8'h40, F_INX,  4, 0);
        run_op("sticky_clamp",  ONE,   8'h08, 1'b0, 8'h38, F_INX,  4, 0);
        run_op("neg_plus_pos",  8'hB8, 8'h3C, 1'b0, 8'h30, F_NONE, 5, 0);
        run_op("underflow",     8'h09, 8'h08, 1'b1, 8'h00, F_UF,   4, 0);
        run_op("zero_minus_b",  8'h00, ONE,   1'b1, 8'hB8, F_NONE, 2, 0);
        run_op("ninf_plus_fin", 8'hF8, ONE,   1'b0, 8'hF8, F_NONE, 2, 0);
        run_op("nan_in",        8'h79, ONE,   1'b0, 8'h7C, F_INV,  2, 0);
        run_op("overflow",      8'h77, 8'h77, 1'b0, 8'h78, F_OVX,  4, 0);
        run_op("inf_minus_inf", 8'h78, 8'h78, 1'b1, 8'h7C, F_INV,  2, 0);

        // abort an operation while it is normalising
        @(negedge clk);
        bus.a        = 8'h39;
        bus.b        = ONE;
        bus.op       = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort/out_valid", 32'(bus.out_valid), 32'(0));
        check("abort/in_ready", 32'(bus.in_ready), 32'(0));
        check("abort/result", 32'(bus.result), 32'(0));
        check("abort/flags", 32'(bus.flags), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort/in_ready_rise", 32'(bus.in_ready), 32'(1));
        seen_valid = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen_valid++;
        end
        check("abort/no_output", 32'(seen_valid), 32'(0));

        run_op("after_abort",   ONE,   ONE,   1'b0, 8'h40, F_NONE, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_fpu_addsub.md
PARAM_FPU_ADDSUB -- requirements
Module: param_fpu_addsub

Interface
REQ-001 The block SHALL have parameter EXP_W, default 4, exponent field width (>=3).
REQ-002 The block SHALL have parameter MAN_W, default 3, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-004 The block SHALL have these data ports: a  in  W  operand A {sign, exp, frac}; b  in  W  operand B; op  in  1  0=A+B, 1=A-B; in_valid  in  1  operands present; in_ready  out  1  block can accept.
REQ-005 The block SHALL have these result ports: result  out  W  sum/difference; flags  out  4  {invalid, overflow, underflow, inexact}; out_valid  out  1  result present; out_ready  in  1  consumer takes result.

Function
REQ-006 The encoding SHALL use bias 2^(EXP_W-1)-1 and a hidden leading 1. Exp=0 is zero: any fraction is flushed, and zero results are always +0. Exp=all-ones with frac=0 is +/-infinity; with frac!=0 it is NaN.
REQ-007 An operation SHALL be accepted on the edge where in_valid && in_ready; a, b and op are registered then, and later input changes are ignored.
REQ-008 in_ready SHALL equal (state==IDLE) && !rst, and out_valid SHALL equal (state==DONE).
REQ-009 The FSM SHALL have states IDLE, ALIGN, ADD, NORM, ROUND, DONE, with these transitions:
- IDLE->ALIGN on accept.
- ALIGN->ADD.
- ADD->NORM, or ADD->DONE if the result is special or the sum is zero.
- NORM->NORM while shifting left.
- NORM->ROUND.
- ROUND->DONE.
- DONE->IDLE on out_ready.
REQ-010 ALIGN SHALL:
- order the operands so the larger magnitude is first;
- right-shift the smaller significand by the exponent difference into a MAN_W+4-bit field with guard, round and sticky bits;
- clamp shifts >= MAN_W+3 so the sticky bit keeps any nonzero bit.
REQ-011 ADD SHALL add when effective signs match and subtract otherwise. The result sign is the sign of the larger-magnitude operand, and 0 when the exact result is zero.
REQ-012 NORM SHALL work one step per cycle:
- on carry-out, shift right by 1, OR the lost bit into sticky, and increment the exponent;
- otherwise, while the leading bit is 0 and exp>1, shift left by 1 and decrement the exponent;
- if the leading bit is still 0 at exp=1, flush to +0 with underflow=1.
REQ-013 ROUND SHALL round to nearest, ties to even. A mantissa overflow from rounding SHALL increment the exponent with fraction 0. inexact SHALL equal guard|round|sticky before rounding.
REQ-014 A final exponent >= all-ones SHALL produce signed infinity, with overflow=1 and inexact=1.
REQ-015 Special inputs SHALL be handled as follows:
- NaN in, or inf-inf effective subtraction, gives canonical NaN {0, all-ones, 1000..0} with invalid=1.
- inf op finite gives that infinity with flags 0.
- A zero operand gives the other operand unchanged, negated if it is b under op=1.
- +0-+0 gives +0.
REQ-016 Latency from the accept edge to out_valid high SHALL be 4+L cycles, where L is the number of NORM left shifts (max MAN_W+1). Special, zero-sum and cancellation-to-zero results SHALL take 2 cycles.
REQ-017 result and flags SHALL be held stable while out_valid && !out_ready. There SHALL be no accept in the same cycle as DONE->IDLE, giving at most 1 operation in flight.

Reset
REQ-018 rst SHALL immediately force state=IDLE, out_valid=0, in_ready=0, result=0 and flags=0; an operation in flight is discarded without output.
REQ-019 in_ready SHALL rise in the first cycle with rst low.

Structure
REQ-020 Package fpu_pkg SHALL hold the FSM state enum, the flag bit indices, and functions for bias, canonical NaN and infinity given EXP_W/MAN_W.
REQ-021 Round-to-nearest-even SHALL live in combinational sub-module fpu_round_rne (inputs: significand, guard/round/sticky, exp; outputs: rounded significand, exp, inexact).
REQ-022 All widths SHALL derive from EXP_W/MAN_W; no literal format widths.

Verification (defaults EXP_W=4, MAN_W=3; 1.0=0x38)
REQ-023 The bench SHALL cover these scenarios:
- 0x38 + 0x38, op=0 -> 0x40, flags 0, out_valid 4 cycles after accept.
- 0x3C + 0x28 (1.5+0.25) -> 0x3E, flags 0.
- 0x39 op=1 0x38 -> 0x20 after 7 cycles (3 left shifts). Separately, 0x38 op=1 0x38 -> 0x00 after 2 cycles.
- 0x38+0x18 -> 0x38 inexact=1 (tie to even). 0x39+0x18 -> 0x3A inexact=1.
- 0x77+0x77 -> 0x78, overflow=1 and inexact=1. 0x78 op=1 0x78 -> 0x7C, invalid=1.
- rst pulsed during NORM -> no out_valid, in_ready=1 next cycle. Separately, out_ready held low 5 cycles -> result stable, then handshake completes.
